sample03_sched: RTL and testbench
=================================

SAMPLE03_SCHED -- requirements
Module: sample03_sched

Interface
REQ-001 The block SHALL have no parameters; the schedule is fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to evaluate one operand set; sampled only when ready.
REQ-005 x, y, z, u, v, w  input  1 each  operands; sampled in the cycle start is accepted.
REQ-006 r, s, t  output  1 each  registered results: r = ((x&y&z)|u|w) & (v|x|y), s = u&w, t = !z.
REQ-007 busy  output  1  high while a schedule step S1..S5 is executing.
REQ-008 done  output  1  one-cycle pulse; r/s/t are valid and updated in this cycle.
REQ-009 step  output  3  current step index: 0 = IDLE, 1..5 = S1..S5, 6 = DONE.

Function
REQ-010 The datapath SHALL use at most one 2-input AND, one 2-input OR and one NOT operation per cycle, executed in the shared functional unit.
REQ-011 The FSM SHALL have states IDLE, S1, S2, S3, S4, S5, DONE.
REQ-012 Start SHALL be accepted only in IDLE or DONE (ready = !busy); acceptance SHALL latch x..w into operand registers and move to S1.
REQ-013 S1 SHALL compute n1=x&y (AND), m1=v|x (OR) and tt=!z (NOT).
REQ-014 S2 SHALL compute n=n1&z (AND) and m=m1|y (OR).
REQ-015 S3 SHALL compute ss=u&w (AND) and p=n|u (OR).
REQ-016 S4 SHALL compute q=p|w (OR).
REQ-017 S5 SHALL compute rr=q&m (AND) and load r, s, t from rr, ss, tt simultaneously on the same edge.
REQ-018 Each S-state SHALL advance unconditionally to the next; S5 SHALL go to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle, then go to IDLE, or to S1 if start=1 in that cycle.
REQ-020 Latency: start sampled high at edge E SHALL produce done=1 during the cycle following edge E+5; S1..S5 occupy the five cycles following edge E.
REQ-021 start while busy SHALL be ignored, with no effect on operands, state or results.
REQ-022 Operand changes after acceptance SHALL NOT affect the results of that evaluation.
REQ-023 r, s, t SHALL hold their last values until the next S5 edge; intermediates SHALL never appear on the outputs.
REQ-024 busy SHALL be 1 exactly in S1..S5.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE with r=s=t=0, done=0, busy=0, step=0, and all operand and intermediate registers cleared.
REQ-026 Reset mid-schedule SHALL abandon the evaluation with no done pulse.
REQ-027 A start sampled in the same cycle as rst SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE..DONE, 3-bit encoding equal to step) and the step-count constant NUM_STEPS=5.
REQ-029 One sub-module, sample03_fu, SHALL contain the single AND/OR/NOT units with operand select inputs driven by the FSM; sample03_sched SHALL hold the FSM and all registers.

Verification
REQ-030 x=y=z=1, u=v=w=0, start -> done in cycle E+6; r=1, s=0, t=0.
REQ-031 All operands 0, start -> r=0, s=0, t=1 at done.
REQ-032 x=y=z=0, u=v=w=1, start; toggle all operands in the cycle after acceptance -> r=1, s=1, t=1 (latched values).
REQ-033 Pulse start during S2 and S4 with different operands -> exactly one done; results from the first operand set; step sequence 1..6 uninterrupted.
REQ-034 rst=1 while step=3 -> next cycle step=0, r=s=t=0, no done; a new start then completes normally 6 cycles later.
REQ-035 start=1 in the DONE cycle with new operands -> step goes 1..5 with busy=1, second done exactly 6 cycles after the first, and r/s/t unchanged until then.

Source files
------------

// File: rtl/sample03_sched_pkg.sv
// sample03_sched_pkg: shared state encoding, step count and operand-source codes
package sample03_sched_pkg;
  localparam int NUM_STEPS = 5;
  localparam int NUM_SRC = 16;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    DONE = 3'd6
  } state_e;
  typedef enum logic [3:0] {
    SRC_X, SRC_Y, SRC_Z, SRC_U, SRC_V, SRC_W,
    SRC_N1, SRC_M1, SRC_N, SRC_M, SRC_P, SRC_Q,
    SRC_ZERO
  } src_e;
  function automatic logic is_busy(state_e s);
    return s inside {S1, S2, S3, S4, S5};
  endfunction
endpackage

// File: rtl/sample03_fu.sv
// sample03_fu: the single shared AND, OR and NOT units with selectable operands
module sample03_fu
  import sample03_sched_pkg::*;
(
  input  logic [NUM_SRC-1:0] src_i,
  input  src_e               and_a_i,
  input  src_e               and_b_i,
  input  src_e               or_a_i,
  input  src_e               or_b_i,
  input  src_e               not_a_i,
  output logic               and_o,
  output logic               or_o,
  output logic               not_o
);
  assign and_o = src_i[and_a_i] & src_i[and_b_i];
  assign or_o  = src_i[or_a_i] | src_i[or_b_i];
  assign not_o = ~src_i[not_a_i];
endmodule

// File: rtl/sample03_sched.sv
// sample03_sched: five-step scheduled evaluation of r, s, t on one shared AND/OR/NOT unit
module sample03_sched
  import sample03_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       x_i,
  input  logic       y_i,
  input  logic       z_i,
  input  logic       u_i,
  input  logic       v_i,
  input  logic       w_i,
  output logic       r_o,
  output logic       s_o,
  output logic       t_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] step_o
);
  state_e state_q, state_d;
  logic x_q, y_q, z_q, u_q, v_q, w_q;
  logic n1_q, m1_q, n_q, m_q, ss_q, tt_q, p_q, q_q;
  logic r_q, s_q, t_q, busy_q, done_q;
  logic ready, accept, fu_and, fu_or, fu_not;
  logic [NUM_SRC-1:0] src;
  src_e and_a, and_b, or_a, or_b, not_a;
  assign ready  = state_q == IDLE || state_q == DONE;
  assign accept = ready && start_i;
  assign src = {4'b0, q_q, p_q, m_q, n_q, m1_q, n1_q, w_q, v_q, u_q, z_q, y_q, x_q};
  // operand routing for the shared unit in each schedule step, plus next state
  always_comb begin
    and_a = state_q == S1 ? SRC_X : state_q == S2 ? SRC_N1 : state_q == S3 ? SRC_U : state_q == S5 ? SRC_Q : SRC_ZERO;
    and_b = state_q == S1 ? SRC_Y : state_q == S2 ? SRC_Z : state_q == S3 ? SRC_W : state_q == S5 ? SRC_M : SRC_ZERO;
    or_a  = state_q == S1 ? SRC_V : state_q == S2 ? SRC_M1 : state_q == S3 ? SRC_N : state_q == S4 ? SRC_P : SRC_ZERO;
    or_b  = state_q == S1 ? SRC_X : state_q == S2 ? SRC_Y : state_q == S3 ? SRC_U : state_q == S4 ? SRC_W : SRC_ZERO;
    not_a = state_q == S1 ? SRC_Z : SRC_ZERO;
    state_d = ready ? (start_i ? S1 : IDLE)
            : state_q == state_e'(3'(NUM_STEPS)) ? DONE
            : state_e'(state_q + 3'd1);
  end
  sample03_fu u_fu (
    .src_i   (src),
    .and_a_i (and_a),
    .and_b_i (and_b),
    .or_a_i  (or_a),
    .or_b_i  (or_b),
    .not_a_i (not_a),
    .and_o   (fu_and),
    .or_o    (fu_or),
    .not_o   (fu_not)
  );
  // FSM, operand latch, per-step intermediates and registered results/status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {x_q, y_q, z_q, u_q, v_q, w_q} <= '0;
      {n1_q, m1_q, n_q, m_q, ss_q, tt_q, p_q, q_q} <= '0;
      {r_q, s_q, t_q, busy_q, done_q} <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= is_busy(state_d);
      done_q  <= state_d == DONE;
      if (accept) {x_q, y_q, z_q, u_q, v_q, w_q} <= {x_i, y_i, z_i, u_i, v_i, w_i};
      if (state_q == S1) begin
        n1_q <= fu_and;
        m1_q <= fu_or;
        tt_q <= fu_not;
      end
      if (state_q == S2) begin
        n_q <= fu_and;
        m_q <= fu_or;
      end
      if (state_q == S3) begin
        ss_q <= fu_and;
        p_q  <= fu_or;
      end
      if (state_q == S4) q_q <= fu_or;
      if (state_q == S5) begin
        r_q <= fu_and;
        s_q <= ss_q;
        t_q <= tt_q;
      end
    end
  end
  assign r_o    = r_q;
  assign s_o    = s_q;
  assign t_o    = t_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign step_o = state_q;
endmodule

// File: tb/tb_sample03_sched.sv
// tb_sample03_sched: directed vectors with a result/latency scoreboard checked on done
module tb_sample03_sched;
  logic clk = 1'b0;
  logic rst, start, x, y, z, u, v, w;
  logic r, s, t, busy, done;
  logic [2:0] step;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [2:0] rst_exp;
    int         cyc_exp;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  sample03_sched dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .x_i     (x),
    .y_i     (y),
    .z_i     (z),
    .u_i     (u),
    .v_i     (v),
    .w_i     (w),
    .r_o     (r),
    .s_o     (s),
    .t_o     (t),
    .busy_o  (busy),
    .done_o  (done),
    .step_o  (step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending evaluation (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("result_rst", {29'b0, r, s, t}, {29'b0, e.rst_exp});
        chk("done_cycle", cyc, e.cyc_exp);
      end
    end
  end

  task automatic set_ops(input logic [5:0] o);
    {x, y, z, u, v, w} = o;
  endtask

  task automatic go(input logic [5:0] o, input logic [2:0] rst_exp, input bit push);
    set_ops(o);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{rst_exp: rst_exp, cyc_exp: cyc + 5});
    start = 1'b0;
  endtask

  task automatic walk(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      chk("step", {29'b0, step}, i);
      chk("busy", {31'b0, busy}, {31'b0, i <= 5});
      chk("done_flag", {31'b0, done}, {31'b0, i == 6});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_ops(6'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_step", {29'b0, step}, 0);
    chk("reset_rst", {29'b0, r, s, t}, 0);
    chk("reset_busy_done", {30'b0, busy, done}, 0);
    // x=y=z=1, u=v=w=0 -> r=1 s=0 t=0
    go(6'b111000, 3'b100, 1'b1);
    walk(1, 6);
    // all zero -> r=0 s=0 t=1
    go(6'b000000, 3'b001, 1'b1);
    walk(1, 6);
    // x=y=z=0, u=v=w=1 then toggle inputs after acceptance -> r=1 s=1 t=1
    go(6'b000111, 3'b111, 1'b1);
    set_ops(6'b111000);
    walk(1, 6);
    // x=1,u=1 others 0 -> r=1 s=0 t=1; restarts during S2 and S4 must be ignored
    go(6'b100100, 3'b101, 1'b1);
    walk(1, 1);
    set_ops(6'b011011);
    start = 1'b1;
    walk(2, 2);
    start = 1'b0;
    walk(3, 3);
    start = 1'b1;
    walk(4, 4);
    start = 1'b0;
    walk(5, 6);
    // reset at step 3 with start high: abandoned, no done, stays idle
    go(6'b111000, 3'b000, 1'b0);
    walk(1, 2);
    chk("pre_reset_step", {29'b0, step}, 3);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("midreset_step", {29'b0, step}, 0);
    chk("midreset_rst", {29'b0, r, s, t}, 0);
    chk("midreset_busy_done", {30'b0, busy, done}, 0);
    @(posedge clk);
    #1;
    chk("post_reset_idle", {29'b0, step}, 0);
    // z=1,u=1,w=1 -> r=0 s=1 t=0
    go(6'b001101, 3'b010, 1'b1);
    walk(1, 6);
    // back-to-back: y=z=1 -> 000, then x=z=w=1 -> 100 accepted in DONE
    go(6'b011000, 3'b000, 1'b1);
    walk(1, 5);
    chk("b2b_done_step", {29'b0, step}, 6);
    go(6'b101001, 3'b100, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      chk("b2b_step", {29'b0, step}, i);
      chk("b2b_busy", {31'b0, busy}, 1);
      chk("b2b_hold_rst", {29'b0, r, s, t}, 0);
      @(posedge clk);
      #1;
    end
    walk(6, 6);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_idle", {29'b0, step}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
